// File: rtl/block_cipher_iter.sv
// Iterative Feistel block cipher, one round per clock, one block in flight.
// Runtime key and encrypt/decrypt mode are captured with the input block.
module block_cipher_iter #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int H     = DATA_W / 2;
    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [H-1:0]      l_q, r_q;
    logic [H-1:0]      rk, f_out, l_next, r_next;
    logic [DATA_W-1:0] key_q, out_q;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last;
    int                ridx, shamt;

    // Decrypt walks the key schedule backwards; rotation wraps mod DATA_W.
    always_comb begin
        ridx   = mode_q ? (ROUNDS - 1 - int'(cnt_q)) : int'(cnt_q);
        shamt  = ridx % DATA_W;
        rk     = H'(({key_q, key_q} << shamt) >> DATA_W);
        f_out  = {r_q[H-2:0], r_q[H-1]} + rk;
        l_next = r_q;
        r_next = l_q ^ f_out;
        last   = (cnt_q == CNT_W'(ROUNDS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_q    <= '0;
            r_q    <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    l_q    <= in_data[DATA_W-1:H];
                    r_q    <= in_data[H-1:0];
                    key_q  <= key;
                    mode_q <= mode;
                    cnt_q  <= '0;
                end
                RUN: begin
                    l_q   <= l_next;
                    r_q   <= r_next;
                    cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
                    // Final swap folded into the result register.
                    if (last) out_q <= {r_next, l_next};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_block_cipher_iter.sv
// Directed bench for block_cipher_iter: 8-bit/4-round vectors plus a
// 16-bit/20-round encrypt/decrypt round-trip sweep.
module tb_block_cipher_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  a_in_data, a_key, a_out_data;
    logic        a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;

    logic [15:0] b_in_data, b_key, b_out_data;
    logic        b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    block_cipher_iter #(.DATA_W(8), .ROUNDS(4)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .key(a_key), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy)
    );

    block_cipher_iter #(.DATA_W(16), .ROUNDS(20)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .key(b_key), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a block, hold in_valid until the accepting edge, then drop it.
    task automatic a_start(input logic [7:0] d, input logic [7:0] k, input logic m);
        int t;
        t = 0;
        a_in_data = d; a_key = k; a_mode = m; a_in_valid = 1'b1;
        while (!a_in_ready && t < 50) begin @(negedge clk); t++; end
        check("a_accept_wait", 32'(t < 50), 1);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic b_run(input logic [15:0] d, input logic [15:0] k, input logic m,
                         output logic [15:0] res, output int lat);
        int t;
        t = 0;
        b_in_data = d; b_key = k; b_mode = m; b_in_valid = 1'b1;
        while (!b_in_ready && t < 50) begin @(negedge clk); t++; end
        check("b_accept_wait", 32'(t < 50), 1);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 200) begin @(negedge clk); lat++; end
        res = b_out_data;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen;
        logic [15:0] pt, kk, ct, rt;

        rst = 1'b0;
        a_in_data = '0; a_key = '0; a_mode = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_key = '0; b_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy",      a_busy,      0);
        check("rst_out_data",  a_out_data,  0);
        rst = 1'b1;
        @(negedge clk);

        // Encrypt F1 / A5 -> D9
        a_start(8'hF1, 8'hA5, 1'b0);
        check("enc_busy",     a_busy,     1);
        check("enc_in_ready", a_in_ready, 0);
        a_wait(lat);
        check("enc_latency", lat, 4);
        check("enc_data",    a_out_data, 8'hD9);
        @(negedge clk);
        check("enc_drained",  a_out_valid, 0);
        check("enc_ready_again", a_in_ready, 1);

        // Decrypt D9 / A5 -> F1
        a_start(8'hD9, 8'hA5, 1'b1);
        a_wait(lat);
        check("dec_latency", lat, 4);
        check("dec_data",    a_out_data, 8'hF1);
        @(negedge clk);
        check("dec_drained", a_out_valid, 0);

        // Backpressure: result held for 10 cycles
        a_out_ready = 1'b0;
        a_start(8'hF1, 8'hA5, 1'b0);
        a_wait(lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid",    a_out_valid, 1);
            check("bp_data",     a_out_data,  8'hD9);
            check("bp_in_ready", a_in_ready,  0);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained",  a_out_valid, 0);
        check("bp_in_ready_after", a_in_ready, 1);

        // Busy isolation: inputs churn and in_valid stays high while busy
        a_start(8'hF1, 8'hA5, 1'b0);
        seen = 0;
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            a_in_data = 8'($urandom); a_key = 8'($urandom); a_mode = ~a_mode;
            a_in_valid = 1'b1;
            @(negedge clk);
            lat++;
            if (a_in_ready) seen++;
        end
        check("iso_latency", lat, 4);
        check("iso_no_accept", seen, 0);
        check("iso_data", a_out_data, 8'hD9);
        @(negedge clk);
        check("iso_no_accept_on_drain", a_in_ready, 1);
        a_in_valid = 1'b0;
        @(negedge clk);
        check("iso_idle", a_busy, 0);

        // Reset during round 2
        a_start(8'hF1, 8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_busy_before", a_busy, 1);
        rst = 1'b0;
        #1;
        check("mid_out_valid", a_out_valid, 0);
        check("mid_busy",      a_busy,      0);
        check("mid_in_ready",  a_in_ready,  1);
        check("mid_out_data",  a_out_data,  0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        a_start(8'hF1, 8'hA5, 1'b0);
        a_wait(lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_data",    a_out_data, 8'hD9);
        @(negedge clk);

        // 16-bit, 20 rounds: round trip with key rotation wrap
        for (int i = 0; i < 200; i++) begin
            pt = 16'($urandom);
            kk = 16'($urandom);
            b_run(pt, kk, 1'b0, ct, lat);
            check("w16_enc_latency", lat, 20);
            b_run(ct, kk, 1'b1, rt, lat);
            check("w16_dec_latency", lat, 20);
            check("w16_roundtrip", rt, pt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
